rns_banked_reg_file: RTL and testbench

RNS_BANKED_REG_FILE -- requirements
Module: rns_banked_reg_file

---
 rtl/rns_banked_reg_file.sv | 149 ++++++++++++++
 tb/tb_rns_banked_reg_file.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rns_banked_reg_file.sv
// Two-bank register file: an 8-bit integer bank and an RNS bank of
// NUM_DOMAINS 8-bit residues per entry. Includes a sequential clear engine.
// Ports:
//   clk, reset (async, active low)
//   rd_addr1/2 : {bank, index}; rd_data1/2, rd_valid1/2 are combinational
//   rd_addr3   : integer-bank index; rd_data3 is combinational
//   wr_en, wr_RNS, wr_addr, wr_data, wr_dom_mask : write port
//   wr_drop    : registered pulse, a write arrived during CLEAR
//   clr_req    : starts a clear; clr_busy while clearing, clr_done one cycle after
module rns_banked_reg_file #(
  parameter int NUM_DOMAINS = 2,
  parameter int DEPTH       = 8,
  parameter int AW          = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [AW:0]              rd_addr1,
  input  logic [AW:0]              rd_addr2,
  output logic [NUM_DOMAINS*8-1:0] rd_data1,
  output logic [NUM_DOMAINS*8-1:0] rd_data2,
  output logic                     rd_valid1,
  output logic                     rd_valid2,
  input  logic [AW-1:0]            rd_addr3,
  output logic [7:0]               rd_data3,
  input  logic                     wr_en,
  input  logic                     wr_RNS,
  input  logic [AW-1:0]            wr_addr,
  input  logic [NUM_DOMAINS*8-1:0] wr_data,
  input  logic [NUM_DOMAINS-1:0]   wr_dom_mask,
  output logic                     wr_drop,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);
  localparam int DW = NUM_DOMAINS * 8;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t                   state;
  logic [AW-1:0]            idx;
  logic [DEPTH-1:0][7:0]    int_mem;
  logic [DEPTH-1:0][DW-1:0] rns_mem;
  logic [DEPTH-1:0]         int_vld;
  logic [DEPTH-1:0]         rns_vld;
  logic                     wr_acc;
  logic [DW-1:0]            rns_merged;

  assign wr_acc = wr_en && (state != CLEAR);

  // Post-write RNS entry at wr_addr; shared by storage update and bypass,
  // since a bypass hit always addresses the same entry.
  for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_merge
    assign rns_merged[8*d +: 8] = wr_dom_mask[d] ? wr_data[8*d +: 8]
                                                 : rns_mem[wr_addr][8*d +: 8];
  end

  // Read ports 1 and 2
  logic [1:0][AW:0] rd_addr;
  logic [1:0][DW-1:0] rd_data;
  logic [1:0] rd_valid;
  assign rd_addr = {rd_addr2, rd_addr1};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic          is_rns;
    logic [AW-1:0] ix;
    logic          hit;
    always_comb begin
      is_rns = rd_addr[p][AW];
      ix     = rd_addr[p][AW-1:0];
      hit    = wr_acc && (wr_RNS == is_rns) && (wr_addr == ix);
      if (is_rns) begin
        rd_data[p]  = hit ? rns_merged : rns_mem[ix];
        rd_valid[p] = hit | rns_vld[ix];
      end else begin
        rd_data[p]  = DW'(hit ? wr_data[7:0] : int_mem[ix]);
        rd_valid[p] = hit | int_vld[ix];
      end
    end
  end

  assign rd_data1  = rd_data[0];
  assign rd_data2  = rd_data[1];
  assign rd_valid1 = rd_valid[0];
  assign rd_valid2 = rd_valid[1];

  assign rd_data3 = (wr_acc && !wr_RNS && (wr_addr == rd_addr3)) ? wr_data[7:0]
                                                                  : int_mem[rd_addr3];

  // Storage. Writes and clear never collide: writes are refused in CLEAR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_mem <= '0;
      rns_mem <= '0;
      int_vld <= '0;
      rns_vld <= '0;
    end else if (state == CLEAR) begin
      int_mem[idx] <= '0;
      rns_mem[idx] <= '0;
      int_vld[idx] <= 1'b0;
      rns_vld[idx] <= 1'b0;
    end else if (wr_acc) begin
      if (wr_RNS) begin
        rns_mem[wr_addr] <= rns_merged;
        rns_vld[wr_addr] <= 1'b1;
      end else begin
        int_mem[wr_addr] <= wr_data[7:0];
        int_vld[wr_addr] <= 1'b1;
      end
    end
  end

  // Clear sequencer with registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      wr_drop <= wr_en && (state == CLEAR);
      case (state)
        IDLE: if (clr_req) begin
          state    <= CLEAR;
          idx      <= '0;
          clr_busy <= 1'b1;
        end
        CLEAR: begin
          if (idx == AW'(DEPTH - 1)) begin
            state    <= DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rns_banked_reg_file.sv
module tb_rns_banked_reg_file;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rd_addr1, rd_addr2;
  logic [15:0] rd_data1, rd_data2;
  logic        rd_valid1, rd_valid2;
  logic [2:0]  rd_addr3;
  logic [7:0]  rd_data3;
  logic        wr_en, wr_RNS;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_dom_mask;
  logic        wr_drop, clr_req, clr_busy, clr_done;

  int checks = 0;
  int errors = 0;

  rns_banked_reg_file #(.NUM_DOMAINS(2), .DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_valid1(rd_valid1), .rd_valid2(rd_valid2),
    .rd_addr3(rd_addr3), .rd_data3(rd_data3),
    .wr_en(wr_en), .wr_RNS(wr_RNS), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dom_mask(wr_dom_mask), .wr_drop(wr_drop),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  // One write spanning a single rising edge; returns on the following negedge.
  task automatic do_write(input logic rns, input logic [2:0] a,
                          input logic [15:0] d, input logic [1:0] m);
    @(negedge clk);
    wr_en = 1'b1; wr_RNS = rns; wr_addr = a; wr_data = d; wr_dom_mask = m;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (rd_data1 !== 16'h0) begin errors++; $display("FAIL reset_rd_data1 got %h exp 0000", rd_data1); end
    checks++; if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b%b exp 00", rd_valid1, rd_valid2); end
    checks++; if (rd_data3 !== 8'h0) begin errors++; $display("FAIL reset_rd_data3 got %h exp 00", rd_data3); end
    checks++; if ({clr_busy, clr_done, wr_drop} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {clr_busy, clr_done, wr_drop}); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_int_write;
    do_write(1'b0, 3'd5, 16'hFFA7, 2'b00);
    rd_addr1 = 4'b0101; rd_addr2 = 4'b1101; rd_addr3 = 3'd5;
    #1;
    checks++; if (rd_data1 !== 16'h00A7) begin errors++; $display("FAIL int_rd_data1 got %h exp 00a7", rd_data1); end
    checks++; if (rd_valid1 !== 1'b1) begin errors++; $display("FAIL int_rd_valid1 got %b exp 1", rd_valid1); end
    checks++; if (rd_data3 !== 8'hA7) begin errors++; $display("FAIL int_rd_data3 got %h exp a7", rd_data3); end
    checks++; if (rd_data2 !== 16'h0 || rd_valid2 !== 1'b0) begin errors++; $display("FAIL int_other_bank got %h/%b exp 0000/0", rd_data2, rd_valid2); end
  endtask

  task automatic test_rns_mask;
    do_write(1'b1, 3'd2, 16'h1234, 2'b11);
    do_write(1'b1, 3'd2, 16'hAB99, 2'b10);
    do_write(1'b1, 3'd6, 16'hFFFF, 2'b00);
    rd_addr1 = 4'b1010; rd_addr2 = 4'b1110;
    #1;
    checks++; if (rd_data1 !== 16'hAB34 || rd_valid1 !== 1'b1) begin errors++; $display("FAIL rns_mask got %h/%b exp ab34/1", rd_data1, rd_valid1); end
    checks++; if (rd_data2 !== 16'h0000 || rd_valid2 !== 1'b1) begin errors++; $display("FAIL rns_zero_mask got %h/%b exp 0000/1", rd_data2, rd_valid2); end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    rd_addr2 = 4'b1011;
    wr_en = 1'b1; wr_RNS = 1'b1; wr_addr = 3'd3; wr_data = 16'h5A5A; wr_dom_mask = 2'b11;
    #1;
    checks++; if (rd_data2 !== 16'h5A5A || rd_valid2 !== 1'b1) begin errors++; $display("FAIL bypass_rns got %h/%b exp 5a5a/1", rd_data2, rd_valid2); end
    @(negedge clk);
    rd_addr1 = 4'b1010;
    wr_addr = 3'd2; wr_data = 16'h77CC; wr_dom_mask = 2'b01;
    #1;
    checks++; if (rd_data1 !== 16'hABCC) begin errors++; $display("FAIL bypass_masked got %h exp abcc", rd_data1); end
    @(negedge clk);
    rd_addr1 = 4'b0001; rd_addr3 = 3'd1;
    wr_RNS = 1'b0; wr_addr = 3'd1; wr_data = 16'hEE3C;
    #1;
    checks++; if (rd_data3 !== 8'h3C) begin errors++; $display("FAIL bypass_port3 got %h exp 3c", rd_data3); end
    checks++; if (rd_data1 !== 16'h003C || rd_valid1 !== 1'b1) begin errors++; $display("FAIL bypass_int got %h/%b exp 003c/1", rd_data1, rd_valid1); end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_clear;
    int busy_n, done_n;
    for (int i = 0; i < 8; i++) begin
      do_write(1'b0, 3'(i), 16'(8'h10 + i), 2'b00);
      do_write(1'b1, 3'(i), {8'(8'h20 + i), 8'(8'h30 + i)}, 2'b11);
    end
    // clr_req coincides with an accepted write, which the clear must erase
    @(negedge clk);
    clr_req = 1'b1;
    wr_en = 1'b1; wr_RNS = 1'b0; wr_addr = 3'd7; wr_data = 16'h0099;
    rd_addr1 = 4'b1111;
    busy_n = 0; done_n = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      clr_req = 1'b0; wr_en = 1'b0;
      if (c == 0) begin
        checks++; if (rd_data1 !== 16'h2737) begin errors++; $display("FAIL clear_old_contents got %h exp 2737", rd_data1); end
      end
      busy_n += int'(clr_busy);
      done_n += int'(clr_done);
    end
    checks++; if (busy_n !== 8) begin errors++; $display("FAIL clear_busy_cycles got %0d exp 8", busy_n); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL clear_done_cycles got %0d exp 1", done_n); end
    for (int i = 0; i < 8; i++) begin
      rd_addr1 = {1'b0, 3'(i)}; rd_addr2 = {1'b1, 3'(i)}; rd_addr3 = 3'(i);
      #1;
      checks++;
      if (rd_data1 !== 16'h0 || rd_data2 !== 16'h0 || rd_data3 !== 8'h0 || rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin
        errors++; $display("FAIL clear_entry_%0d got %h/%h/%h/%b%b exp all 0", i, rd_data1, rd_data2, rd_data3, rd_valid1, rd_valid2);
      end
    end
  endtask

  task automatic test_drop;
    int busy_n, done_n;
    @(negedge clk);
    clr_req = 1'b1;
    busy_n = 0; done_n = 0;
    for (int c = 1; c < 16; c++) begin
      @(negedge clk);
      clr_req = (c == 5);  // ignored: sequence already running
      wr_en = (c == 3);    // 3rd CLEAR cycle
      wr_RNS = 1'b0; wr_addr = 3'd1; wr_data = 16'h0055;
      if (c == 1) begin
        checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL drop_idle got %b exp 0", wr_drop); end
      end
      if (c == 4) begin
        checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b exp 1", wr_drop); end
      end
      if (c == 5) begin
        checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL drop_after got %b exp 0", wr_drop); end
      end
      busy_n += int'(clr_busy);
      done_n += int'(clr_done);
    end
    clr_req = 1'b0; wr_en = 1'b0;
    checks++; if (busy_n !== 8 || done_n !== 1) begin errors++; $display("FAIL clr_req_ignored got busy %0d done %0d exp 8 1", busy_n, done_n); end
    rd_addr3 = 3'd1; rd_addr1 = 4'b0001;
    #1;
    checks++; if (rd_data3 !== 8'h0 || rd_valid1 !== 1'b0) begin errors++; $display("FAIL drop_target got %h/%b exp 00/0", rd_data3, rd_valid1); end
  endtask

  task automatic test_async_reset;
    int done_n;
    do_write(1'b0, 3'd3, 16'h0033, 2'b00);
    rd_addr1 = 4'b0011; rd_addr2 = 4'b1011; rd_addr3 = 3'd3;
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (rd_data1 !== 16'h0033 || clr_busy !== 1'b1) begin errors++; $display("FAIL pre_reset got %h/%b exp 0033/1", rd_data1, clr_busy); end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b exp 0", clr_busy); end
    checks++; if (rd_data1 !== 16'h0 || rd_data3 !== 8'h0 || rd_valid1 !== 1'b0) begin errors++; $display("FAIL async_reads got %h/%h/%b exp 0000/00/0", rd_data1, rd_data3, rd_valid1); end
    @(negedge clk);
    reset = 1'b1;
    done_n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      done_n += int'(clr_done) + int'(clr_busy);
    end
    checks++; if (done_n !== 0) begin errors++; $display("FAIL async_no_done got %0d exp 0", done_n); end
  endtask

  initial begin
    reset = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0; rd_addr3 = '0;
    wr_en = 1'b0; wr_RNS = 1'b0; wr_addr = '0; wr_data = '0; wr_dom_mask = '0;
    clr_req = 1'b0;
    test_reset;
    test_int_write;
    test_rns_mask;
    test_bypass;
    test_clear;
    test_drop;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
